// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor with valid/ready handshake.
// Stage 1 aligns and classifies, stage 2 adds or subtracts, and stage 3
// normalises, rounds (nearest-even) and registers the result and flags.
// Denormal inputs and results are flushed to zero.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         command,
  input  logic [W-1:0] number1,
  input  logic [W-1:0] number2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic [2:0]   flags
);

  // Mantissa with hidden bit plus guard, round and sticky.
  localparam int M    = MAN_W + 4;
  localparam int LZ_W = $clog2(M + 1);
  // Exponent working width: holds exp + 1 and lzc without wrapping.
  localparam int XW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- Stage 1: classify and align ----------------
  logic               sign1, sign2;
  logic [EXP_W-1:0]   exp1, exp2;
  logic [MAN_W-1:0]   frac1, frac2;
  logic               nan1, nan2, inf1, inf2, zero1, zero2;

  assign sign1 = number1[W-1];
  assign sign2 = number2[W-1] ^ command;
  assign exp1  = number1[W-2:MAN_W];
  assign exp2  = number2[W-2:MAN_W];
  // A zero exponent flushes the fraction, so denormals behave as zeros.
  assign frac1 = (exp1 == '0) ? '0 : number1[MAN_W-1:0];
  assign frac2 = (exp2 == '0) ? '0 : number2[MAN_W-1:0];
  assign nan1  = (exp1 == EXP_ONES) && (frac1 != '0);
  assign nan2  = (exp2 == EXP_ONES) && (frac2 != '0);
  assign inf1  = (exp1 == EXP_ONES) && (frac1 == '0);
  assign inf2  = (exp2 == EXP_ONES) && (frac2 == '0);
  assign zero1 = (exp1 == '0);
  assign zero2 = (exp2 == '0);

  logic             s1_special_d, s1_special_q;
  logic [W-1:0]     s1_spec_res_d, s1_spec_res_q;
  logic [2:0]       s1_spec_flags_d, s1_spec_flags_q;
  logic             s1_valid_q;
  logic             s1_sign_d, s1_sign_q;
  logic [EXP_W-1:0] s1_exp_d, s1_exp_q;
  logic             s1_sub_q;
  logic [M-1:0]     s1_ma_d, s1_ma_q;
  logic [M-1:0]     s1_mb_d, s1_mb_q;

  // Special-value resolution; these results bypass the arithmetic path.
  always_comb begin
    s1_special_d    = 1'b1;
    s1_spec_res_d   = '0;
    s1_spec_flags_d = '0;
    if (nan1 || nan2) begin
      s1_spec_res_d = QNAN;
    end else if (inf1 && inf2 && (sign1 != sign2)) begin
      s1_spec_res_d   = QNAN;
      s1_spec_flags_d = 3'b100;
    end else if (inf1) begin
      s1_spec_res_d = {sign1, EXP_ONES, {MAN_W{1'b0}}};
    end else if (inf2) begin
      s1_spec_res_d = {sign2, EXP_ONES, {MAN_W{1'b0}}};
    end else if (zero1 && zero2) begin
      s1_spec_res_d = {sign1 & sign2, {(W-1){1'b0}}};
    end else begin
      s1_special_d = 1'b0;
    end
  end

  logic             swap;
  logic [EXP_W-1:0] exp_b, diff;
  logic [M-1:0]     mb_raw, sticky_mask;
  logic             sticky;

  // Order by magnitude so A >= B, then shift B right keeping a sticky bit.
  always_comb begin
    swap = {exp2, frac2} > {exp1, frac1};
    if (swap) begin
      s1_sign_d = sign2;
      s1_exp_d  = exp2;
      exp_b     = exp1;
      s1_ma_d   = {(exp2 != '0), frac2, 3'b000};
      mb_raw    = {(exp1 != '0), frac1, 3'b000};
    end else begin
      s1_sign_d = sign1;
      s1_exp_d  = exp1;
      exp_b     = exp2;
      s1_ma_d   = {(exp1 != '0), frac1, 3'b000};
      mb_raw    = {(exp2 != '0), frac2, 3'b000};
    end
    diff        = s1_exp_d - exp_b;
    sticky_mask = ~({M{1'b1}} << diff);
    sticky      = |(mb_raw & sticky_mask);
    s1_mb_d     = (mb_raw >> diff) | {{(M-1){1'b0}}, sticky};
    if (32'(diff) >= 32'(MAN_W + 3)) begin
      s1_mb_d = {{(M-1){1'b0}}, |mb_raw};
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q      <= 1'b0;
      s1_sign_q       <= 1'b0;
      s1_exp_q        <= '0;
      s1_sub_q        <= 1'b0;
      s1_ma_q         <= '0;
      s1_mb_q         <= '0;
      s1_special_q    <= 1'b0;
      s1_spec_res_q   <= '0;
      s1_spec_flags_q <= '0;
    end else if (advance) begin
      s1_valid_q      <= in_valid;
      s1_sign_q       <= s1_sign_d;
      s1_exp_q        <= s1_exp_d;
      s1_sub_q        <= sign1 ^ sign2;
      s1_ma_q         <= s1_ma_d;
      s1_mb_q         <= s1_mb_d;
      s1_special_q    <= s1_special_d;
      s1_spec_res_q   <= s1_spec_res_d;
      s1_spec_flags_q <= s1_spec_flags_d;
    end
  end

  // ---------------- Stage 2: add / subtract ----------------
  logic             s2_valid_q;
  logic             s2_sign_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [M:0]       s2_sum_d, s2_sum_q;
  logic             s2_special_q;
  logic [W-1:0]     s2_spec_res_q;
  logic [2:0]       s2_spec_flags_q;

  // A >= B, so the difference never goes negative.
  assign s2_sum_d = s1_sub_q ? ({1'b0, s1_ma_q} - {1'b0, s1_mb_q})
                             : ({1'b0, s1_ma_q} + {1'b0, s1_mb_q});

  // Stage 2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q      <= 1'b0;
      s2_sign_q       <= 1'b0;
      s2_exp_q        <= '0;
      s2_sum_q        <= '0;
      s2_special_q    <= 1'b0;
      s2_spec_res_q   <= '0;
      s2_spec_flags_q <= '0;
    end else if (advance) begin
      s2_valid_q      <= s1_valid_q;
      s2_sign_q       <= s1_sign_q;
      s2_exp_q        <= s1_exp_q;
      s2_sum_q        <= s2_sum_d;
      s2_special_q    <= s1_special_q;
      s2_spec_res_q   <= s1_spec_res_q;
      s2_spec_flags_q <= s1_spec_flags_q;
    end
  end

  // ---------------- Stage 3: normalise and round ----------------
  logic [LZ_W-1:0]  lzc;
  logic             lz_found;
  logic [M-1:0]     m_norm;
  logic [XW-1:0]    exp_x, e_pre, e_fin;
  logic             underflow;
  logic             g_bit, r_bit, s_bit, round_up;
  logic [MAN_W:0]   frac_rnd;
  logic [W-1:0]     s3_sum_d, sum_q;
  logic [2:0]       s3_flags_d, flags_q;
  logic             out_valid_q;

  // Leading-zero count of the non-carry part of the sum.
  always_comb begin
    lzc      = '0;
    lz_found = 1'b0;
    for (int i = M - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (s2_sum_q[i]) lz_found = 1'b1;
        else             lzc = lzc + LZ_W'(1);
      end
    end
  end

  // Normalise, round to nearest-even, then pick special/zero/inf/finite.
  always_comb begin
    exp_x     = XW'(s2_exp_q);
    underflow = 1'b0;
    if (s2_sum_q[M]) begin
      m_norm = {s2_sum_q[M:2], |s2_sum_q[1:0]};
      e_pre  = exp_x + XW'(1);
    end else begin
      m_norm    = s2_sum_q[M-1:0] << lzc;
      underflow = exp_x <= XW'(lzc);
      e_pre     = exp_x - XW'(lzc);
    end
    g_bit    = m_norm[2];
    r_bit    = m_norm[1];
    s_bit    = m_norm[0];
    round_up = g_bit && (r_bit || s_bit || m_norm[3]);
    // A carry out of the fraction means the mantissa rounded up to 2.0:
    // the fraction bits are then all zero and the exponent steps up.
    frac_rnd = {1'b0, m_norm[M-2:3]} + (MAN_W+1)'(round_up);
    e_fin    = e_pre + XW'(frac_rnd[MAN_W]);

    s3_sum_d   = {s2_sign_q, e_fin[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
    s3_flags_d = {2'b00, g_bit | r_bit | s_bit};
    if (s2_special_q) begin
      s3_sum_d   = s2_spec_res_q;
      s3_flags_d = s2_spec_flags_q;
    end else if (!m_norm[M-1]) begin
      // Hidden bit still clear after normalising: exact cancellation.
      s3_sum_d   = '0;
      s3_flags_d = '0;
    end else if (underflow) begin
      s3_sum_d   = {s2_sign_q, {(W-1){1'b0}}};
      s3_flags_d = '0;
    end else if (e_fin >= XW'(EXP_ONES)) begin
      s3_sum_d   = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      s3_flags_d = 3'b011;
    end
  end

  // Output register; holds while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      flags_q     <= '0;
    end else if (advance) begin
      out_valid_q <= s2_valid_q;
      sum_q       <= s3_sum_d;
      flags_q     <= s3_flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe (FP32): vector table, backpressure
// stream and asynchronous reset with beats in flight.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        command;
  logic [31:0] number1;
  logic [31:0] number2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic [2:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;

  fp_addsub_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .command   (command),
    .number1   (number1),
    .number2   (number2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cmd;
    logic [31:0] exp_sum;
    logic [2:0]  exp_flags;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  logic [31:0] bp_b   [8];
  logic [31:0] bp_exp [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // One isolated beat: check 3-cycle latency, then result and flags.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    in_valid  = 1'b1;
    number1   = v.a;
    number2   = v.b;
    command   = v.cmd;
    out_ready = 1'b1;
    #1 chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " valid@1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, " valid@2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, " valid@3"}, 32'(out_valid), 32'd1);
    chk({tag, " sum"}, sum, v.exp_sum);
    chk({tag, " flags"}, 32'(flags), 32'(v.exp_flags));
    $display("[TB] %s a=%08h b=%08h cmd=%0d -> sum=%08h flags=%03b",
             tag, v.a, v.b, v.cmd, sum, flags);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000};
    vecs[1]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000};
    vecs[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
    vecs[3]  = '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000};
    vecs[4]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001};
    vecs[5]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001};
    vecs[6]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100};
    vecs[7]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011};
    vecs[8]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000};
    vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
    vecs[10] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000};
    vecs[11] = '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 3'b000};
    vecs[12] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 3'b000};
    vecs[13] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000};
    vecs[14] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b001};
    vecs[15] = '{32'h80800001, 32'h00800000, 1'b0, 32'h80000000, 3'b000};
    vecs[16] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b001};
    vecs[17] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 3'b011};
    vecs[18] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000};
    vecs[19] = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000};

    // 1.0 + k for k = 1..8
    bp_b[0] = 32'h3F800000; bp_exp[0] = 32'h40000000;
    bp_b[1] = 32'h40000000; bp_exp[1] = 32'h40400000;
    bp_b[2] = 32'h40400000; bp_exp[2] = 32'h40800000;
    bp_b[3] = 32'h40800000; bp_exp[3] = 32'h40A00000;
    bp_b[4] = 32'h40A00000; bp_exp[4] = 32'h40C00000;
    bp_b[5] = 32'h40C00000; bp_exp[5] = 32'h40E00000;
    bp_b[6] = 32'h40E00000; bp_exp[6] = 32'h41000000;
    bp_b[7] = 32'h41000000; bp_exp[7] = 32'h41100000;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    command   = 1'b0;
    number1   = '0;
    number2   = '0;
    out_ready = 1'b1;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset sum", sum, 32'h0);
    chk("reset flags", 32'(flags), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure stream: 8 back-to-back beats, out_ready pattern 1,0,0,1.
    begin
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      logic        held_valid = 1'b0;
      logic [31:0] held_sum   = '0;
      while (got < 8 && cyc < 200) begin
        @(negedge clk);
        out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        in_valid  = (sent < 8);
        number1   = 32'h3F800000;
        command   = 1'b0;
        if (sent < 8) number2 = bp_b[sent];
        #1;
        chk($sformatf("bp in_ready c%0d", cyc), 32'(in_ready),
            32'(!(out_valid && !out_ready)));
        if (held_valid && out_valid) begin
          chk($sformatf("bp stable c%0d", cyc), sum, held_sum);
        end
        held_valid = out_valid && !out_ready;
        held_sum   = sum;
        if (out_valid && out_ready) begin
          chk($sformatf("bp result %0d", got), sum, bp_exp[got]);
          $display("[TB] bp beat %0d out sum=%08h flags=%03b", got, sum, flags);
          got++;
        end
        if (in_valid && in_ready) sent++;
        cyc++;
      end
      chk("bp all received", 32'(got), 32'd8);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk($sformatf("bp no extra %0d", k), 32'(out_valid), 32'd0);
      end
    end

    // Reset with three beats in flight and the output stalled.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      number1  = 32'h3F800000;
      number2  = bp_b[k];
      command  = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst pre out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async out_valid", 32'(out_valid), 32'd0);
    chk("rst async sum", sum, 32'h0);
    chk("rst async flags", 32'(flags), 32'd0);
    $display("[TB] reset asserted with beats in flight");
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rst no stale %0d", k), 32'(out_valid), 32'd0);
    end
    run_vec(vecs[0], "post-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
